// File: rtl/mod_corr_pkg.sv
// rtl/mod_corr_pkg.sv - shared types and width helpers for the modular add/sub correction stage
package mod_corr_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int WBITS_DEFAULT = 64;
    localparam int MAX_NBITS     = 4096;

    // A requested width of 0, or one wider than the datapath, means full width.
    function automatic int eff_bits(input int nb, input int nmax);
        return ((nb == 0) || (nb > nmax)) ? nmax : nb;
    endfunction

    function automatic int num_limbs(input int nb, input int nmax, input int wbits);
        return (eff_bits(nb, nmax) + wbits - 1) / wbits;
    endfunction

    function automatic logic [MAX_NBITS-1:0] width_mask(input int nb, input int nmax);
        return ~({MAX_NBITS{1'b1}} << eff_bits(nb, nmax));
    endfunction

endpackage

// File: rtl/mod_word_addsub.sv
// rtl/mod_word_addsub.sv - one-limb combinational adder/subtractor with carry/borrow chaining
module mod_word_addsub #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         minus,
    output logic [W-1:0] s,
    output logic         cout
);

    // In subtract mode cin/cout are borrows; the extra top bit of the difference is the borrow out.
    always_comb begin
        if (minus) begin
            {cout, s} = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
        end else begin
            {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        end
    end

endmodule

// File: rtl/mod_add_sub_corr.sv
// rtl/mod_add_sub_corr.sv - word-serial modular correction; MOD_ADD_SUB_CORR_ERR_EN adds the err output
module mod_add_sub_corr
    import mod_corr_pkg::*;
#(
    parameter int NBITS = 2048,
    parameter int WBITS = WBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exec_p,
    input  logic             sub,
    input  logic [10:0]      nbits,
    input  logic [NBITS:0]   raw,
    input  logic [NBITS-1:0] m,
    output logic [NBITS-1:0] y,
    output logic             busy,
    output logic             done_irq_p
`ifdef MOD_ADD_SUB_CORR_ERR_EN
    ,
    output logic             err
`endif
);

    localparam int NLIMBS = NBITS / WBITS;
    localparam int CW     = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
    localparam int AW     = (NBITS > 1) ? $clog2(NBITS) : 1;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    k_last;
    logic [NBITS-1:0] raw_lo;
    logic             raw_hi;
    logic [NBITS-1:0] m_lat;
    logic             sub_lat;
    logic [10:0]      nb_lat;
    logic             cb;
    logic [NBITS-1:0] t;

    logic [AW-1:0]    base;
    logic [AW-1:0]    top_idx;
    logic             last;
    logic             top_bit;
    logic             use_t;
    logic [WBITS-1:0] word_s;
    logic             word_cout;
    logic [NBITS-1:0] t_merged;
    logic [NBITS-1:0] y_next;

    assign base    = AW'(int'(cnt) * WBITS);
    assign top_idx = AW'((int'(k_last) + 1) * WBITS);
    assign last    = (cnt == k_last);
    assign busy    = (state != IDLE);

    // The add path reduces by subtracting m; the sub path corrects a negative difference by adding m.
    mod_word_addsub #(
        .W(WBITS)
    ) u_word (
        .a    (raw_lo[base +: WBITS]),
        .b    (m_lat[base +: WBITS]),
        .cin  (cb),
        .minus(~sub_lat),
        .s    (word_s),
        .cout (word_cout)
    );

    always_comb begin
        t_merged = t;
        t_merged[base +: WBITS] = word_s;
        top_bit = (k_last == CW'(NLIMBS - 1)) ? raw_hi : raw_lo[top_idx];
        if (!sub_lat) begin
            use_t = !word_cout || top_bit;
        end else begin
            use_t = !raw_hi;
        end
        y_next = (use_t ? t_merged : raw_lo) & NBITS'(width_mask(int'(nb_lat), NBITS));
    end

`ifdef MOD_ADD_SUB_CORR_ERR_EN
    logic err_next;
    assign err_next = sub_lat ? (!raw_hi && !word_cout) : (top_bit && !word_cout);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (exec_p) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // y and done_irq_p load on the final RUN edge so both are visible throughout the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            k_last     <= '0;
            raw_lo     <= '0;
            raw_hi     <= 1'b0;
            m_lat      <= '0;
            sub_lat    <= 1'b0;
            nb_lat     <= '0;
            cb         <= 1'b0;
            t          <= '0;
            y          <= '0;
            done_irq_p <= 1'b0;
`ifdef MOD_ADD_SUB_CORR_ERR_EN
            err        <= 1'b0;
`endif
        end else begin
            done_irq_p <= 1'b0;
            case (state)
                IDLE: begin
                    if (exec_p) begin
                        raw_lo  <= raw[NBITS-1:0];
                        raw_hi  <= raw[NBITS];
                        m_lat   <= m;
                        sub_lat <= sub;
                        nb_lat  <= nbits;
                        k_last  <= CW'(num_limbs(int'(nbits), NBITS, WBITS) - 1);
                        cnt     <= '0;
                        cb      <= 1'b0;
`ifdef MOD_ADD_SUB_CORR_ERR_EN
                        err     <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    t  <= t_merged;
                    cb <= word_cout;
                    if (last) begin
                        cnt        <= '0;
                        y          <= y_next;
                        done_irq_p <= 1'b1;
`ifdef MOD_ADD_SUB_CORR_ERR_EN
                        err        <= err_next;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_add_sub_corr.sv
// tb/tb_mod_add_sub_corr.sv - directed self-checking bench for mod_add_sub_corr at NBITS=64, WBITS=16
`ifdef MOD_ADD_SUB_CORR_ERR_EN
`define ERR_ARG(v) , v
`else
`define ERR_ARG(v)
`endif

module tb_mod_add_sub_corr;

    logic        clk;
    logic        rst;
    logic        exec_p;
    logic        sub;
    logic [10:0] nbits;
    logic [64:0] raw;
    logic [63:0] m;
    logic [63:0] y;
    logic        busy;
    logic        done_irq_p;
`ifdef MOD_ADD_SUB_CORR_ERR_EN
    logic        err;
`endif

    int          checks;
    int          errors;
    logic [63:0] prev_y;

    mod_add_sub_corr #(
        .NBITS(64),
        .WBITS(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .exec_p    (exec_p),
        .sub       (sub),
        .nbits     (nbits),
        .raw       (raw),
        .m         (m),
        .y         (y),
        .busy      (busy),
        .done_irq_p(done_irq_p)
`ifdef MOD_ADD_SUB_CORR_ERR_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Cycle 0 carries exec_p; xmask[c] drives extra exec_p pulses that must be ignored.
    task automatic run(input string tag, input logic sb, input logic [10:0] nb,
                       input logic [64:0] r, input logic [63:0] mm, input logic [63:0] ey,
                       input int kdone, input logic [7:0] xmask
`ifdef MOD_ADD_SUB_CORR_ERR_EN
                       , input logic eerr
`endif
                       );
        @(posedge clk); #1;
        exec_p = 1'b1; sub = sb; nbits = nb; raw = r; m = mm;
        @(negedge clk);
        chk({tag, "_c0_busy"}, 64'(busy), 64'd0);
        chk({tag, "_c0_done"}, 64'(done_irq_p), 64'd0);
        chk({tag, "_c0_y"}, y, prev_y);
        for (int c = 1; c <= kdone; c++) begin
            @(posedge clk); #1;
            exec_p = xmask[c];
            if (c == 1) begin
                sub = ~sb; nbits = 11'd7;
                raw = 65'h1_DEAD_BEEF_CAFE_F00D; m = 64'h1234_5678_9ABC_DEF0;
            end
            @(negedge clk);
            chk($sformatf("%s_c%0d_busy", tag, c), 64'(busy), 64'd1);
            chk($sformatf("%s_c%0d_done", tag, c), 64'(done_irq_p), 64'(c == kdone));
            chk($sformatf("%s_c%0d_y", tag, c), y, (c == kdone) ? ey : prev_y);
        end
`ifdef MOD_ADD_SUB_CORR_ERR_EN
        chk({tag, "_err"}, 64'(err), 64'(eerr));
`endif
        prev_y = ey;
    endtask

    initial begin
        checks = 0; errors = 0; prev_y = '0;
        rst = 1'b1; exec_p = 1'b0; sub = 1'b0; nbits = '0; raw = '0; m = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_y", y, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done_irq_p), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run("add_reduce", 1'b0, 11'd64, 65'd150, 64'd97, 64'd53, 5, 8'h00 `ERR_ARG(1'b0));
        run("add_keep", 1'b0, 11'd64, 65'd50, 64'd97, 64'd50, 5, 8'h00 `ERR_ARG(1'b0));
        run("sub_neg", 1'b1, 11'd64, 65'h0_FFFF_FFFF_FFFF_FFEC, 64'd97, 64'd77, 5, 8'h00 `ERR_ARG(1'b0));
        run("sub_pos", 1'b1, 11'd64, 65'h1_0000_0000_0000_0014, 64'd97, 64'd20, 5, 8'h00 `ERR_ARG(1'b0));
        run("add_nb16", 1'b0, 11'd16, 65'h0_0000_0000_0001_0005, 64'h0000_0000_0000_FFF1,
            64'h0000_0000_0000_0014, 2, 8'h00 `ERR_ARG(1'b0));
        run("add_nb20", 1'b0, 11'd20, 65'h0_0000_0000_00FF_0005, 64'h0000_0000_0000_FFF1,
            64'h0000_0000_000E_0014, 3, 8'h00 `ERR_ARG(1'b0));
        run("add_nb0", 1'b0, 11'd0, 65'h0_8000_0000_0000_0000, 64'd97,
            64'h7FFF_FFFF_FFFF_FF9F, 5, 8'h00 `ERR_ARG(1'b0));
        run("add_clamp", 1'b0, 11'd100, 65'h1_0000_0000_0000_0005, 64'd97,
            64'hFFFF_FFFF_FFFF_FFA4, 5, 8'h00 `ERR_ARG(1'b0));
        run("exec_busy", 1'b0, 11'd64, 65'd150, 64'd97, 64'd53, 5, 8'b0010_1100 `ERR_ARG(1'b0));

        // Abort a run with rst in cycle 2; nothing may complete and y must clear.
        @(posedge clk); #1;
        exec_p = 1'b1; sub = 1'b0; nbits = 11'd64; raw = 65'd150; m = 64'd97;
        @(negedge clk);
        chk("rstmid_c0_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        exec_p = 1'b0;
        @(negedge clk);
        chk("rstmid_c1_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_y", y, 64'd0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("rstmid_w%0d_busy", c), 64'(busy), 64'd0);
            chk($sformatf("rstmid_w%0d_done", c), 64'(done_irq_p), 64'd0);
        end
        prev_y = '0;

        run("after_rst", 1'b0, 11'd64, 65'd50, 64'd97, 64'd50, 5, 8'h00 `ERR_ARG(1'b0));
        run("add_oor", 1'b0, 11'd64, 65'h1_0000_0000_0000_00C8, 64'd97, 64'd103, 5, 8'h00 `ERR_ARG(1'b1));

        @(posedge clk); #1;
        exec_p = 1'b0;
        @(negedge clk);
        chk("end_busy", 64'(busy), 64'd0);
        chk("end_done", 64'(done_irq_p), 64'd0);
        chk("end_y", y, 64'd103);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
